// File: rtl/cavlc_pkg.sv
// Shared CAVLC types: controller states, nC table classes and the coeff_token lookup result.
package cavlc_pkg;

  localparam int         MAX_COEFF = 16;
  localparam int         FLC_LEN   = 6;
  localparam logic [5:0] FLC_ZERO  = 6'b000011;

  typedef enum logic [2:0] {
    IDLE, FETCH, CLZ, LOOKUP, SHIFT, DONE, ERROR
  } state_t;

  typedef enum logic [2:0] {
    CHROMA_DC, C0, C1, C2, FLC
  } nc_class_t;

  typedef struct packed {
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
    logic [4:0] num_shift;
    logic       valid;
  } coeff_token_t;

  function automatic logic nc_legal(input logic signed [5:0] nc);
    return (nc >= -6'sd1) && (nc <= 6'sd16);
  endfunction

  function automatic nc_class_t nc_to_class(input logic signed [5:0] nc);
    if (nc < 6'sd0)      return CHROMA_DC;
    else if (nc < 6'sd2) return C0;
    else if (nc < 6'sd4) return C1;
    else if (nc < 6'sd8) return C2;
    else                 return FLC;
  endfunction

endpackage

// File: rtl/coeff_token_ctrl_if.sv
// Request/result and bitstream-buffer handshake bundle for the coeff_token controller.
interface coeff_token_ctrl_if #(
  parameter int WIN_W   = 16,
  parameter int SHIFT_W = 5
);
  logic                start;
  logic signed [5:0]   nc;
  logic [WIN_W-1:0]    bit_window;
  logic                window_valid;
  logic                shift_valid;
  logic [SHIFT_W-1:0]  shift_amt;
  logic                shift_ready;
  logic [4:0]          total_coeff;
  logic [1:0]          trailing_ones;
  logic                done;
  logic                error;
  logic                busy;

  modport master (
    output start, nc, bit_window, window_valid, shift_ready,
    input  shift_valid, shift_amt, total_coeff, trailing_ones, done, error, busy
  );

  modport slave (
    input  start, nc, bit_window, window_valid, shift_ready,
    output shift_valid, shift_amt, total_coeff, trailing_ones, done, error, busy
  );
endinterface

// File: rtl/coeff_token_table.sv
// Combinational coeff_token decode: (class, leading zeros, window) -> TC/T1/length/valid.
// Entries are indexed 4*TotalCoeff + TrailingOnes; length 0 marks a pair with no code.
module coeff_token_table
  import cavlc_pkg::*;
#(
  parameter int WIN_W = 16,
  parameter int LZ_W  = $clog2(WIN_W + 1)
) (
  input  nc_class_t        cls,
  input  logic [LZ_W-1:0]  lz,
  input  logic [WIN_W-1:0] window,
  output coeff_token_t     tok
);
  localparam int N_ENT = (MAX_COEFF + 1) * 4;
  localparam int N_CD  = 20;

  localparam logic [4:0] C0_LEN [N_ENT] = '{
     1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,
    11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,  13,13,13,10,  14,14,13,11,
    14,14,14,13,  15,15,14,14,  15,15,15,14,  16,15,15,15,  16,16,16,15,
    16,16,16,16,  16,16,16,16};
  localparam logic [3:0] C0_BITS [N_ENT] = '{
     1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,
     7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,  15,14, 9, 4,
    11,10,13,12,  15,14, 9,12,  11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,
     7,10, 9,12,   4, 6, 5, 8};
  localparam logic [4:0] C1_LEN [N_ENT] = '{
     2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,
     8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,  12,11,11, 9,
    12,12,12,11,  12,12,12,11,  13,13,13,12,  13,13,13,13,  13,14,13,13,
    14,14,14,13,  14,14,14,14};
  localparam logic [3:0] C1_BITS [N_ENT] = '{
     3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,
     4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,  15,10, 9, 4,
    11,14,13,12,   8,10, 9, 8,  15,14,13,12,  11,10, 9,12,   7,11, 6, 8,
     9, 8,10, 1,   7, 6, 5, 4};
  localparam logic [4:0] C2_LEN [N_ENT] = '{
     4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,
     7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,   8, 8, 7, 6,
     9, 8, 8, 7,   9, 9, 8, 8,   9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,
    10,10,10,10,  10,10,10,10};
  localparam logic [3:0] C2_BITS [N_ENT] = '{
    15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,
    11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,  15,14,13,13,  11,14,10,12,
    15,10,13,12,  11,14, 9,12,   8,10,13, 8,  13, 7, 9,12,   9,12,11,10,
     5, 8, 7, 6,   1, 4, 3, 2};
  localparam logic [4:0] CD_LEN [N_CD] = '{
     2, 0, 0, 0,   6, 1, 0, 0,   6, 6, 3, 0,   6, 7, 7, 6,   6, 8, 8, 7};
  localparam logic [3:0] CD_BITS [N_CD] = '{
     1, 0, 0, 0,   7, 1, 0, 0,   4, 6, 1, 0,   3, 3, 2, 5,   2, 3, 2, 0};

  function automatic logic [4:0] ent_len(input nc_class_t c, input int i);
    case (c)
      CHROMA_DC: return (i < N_CD) ? CD_LEN[5'(i)] : 5'd0;
      C0:        return C0_LEN[7'(i)];
      C1:        return C1_LEN[7'(i)];
      C2:        return C2_LEN[7'(i)];
      default:   return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] ent_bits(input nc_class_t c, input int i);
    case (c)
      CHROMA_DC: return (i < N_CD) ? CD_BITS[5'(i)] : 4'd0;
      C0:        return C0_BITS[7'(i)];
      C1:        return C1_BITS[7'(i)];
      C2:        return C2_BITS[7'(i)];
      default:   return 4'd0;
    endcase
  endfunction

  function automatic int bitlen4(input logic [3:0] b);
    if (b[3])      return 4;
    else if (b[2]) return 3;
    else if (b[1]) return 2;
    else if (b[0]) return 1;
    else           return 0;
  endfunction

  logic [15:0] top;
  logic [5:0]  flc_code;
  logic [4:0]  e_len;
  logic [3:0]  e_bits;
  logic [15:0] mask;
  logic [15:0] pat;
  logic        seg_ok;

  always_comb begin
    tok      = '0;
    top      = window[WIN_W-1 -: 16];
    flc_code = window[WIN_W-1 -: FLC_LEN];
    e_len    = '0;
    e_bits   = '0;
    mask     = '0;
    pat      = '0;
    seg_ok   = 1'b0;
    if (cls == FLC) begin
      tok.num_shift = 5'(FLC_LEN);
      if (flc_code == FLC_ZERO) begin
        tok.valid = 1'b1;
      end else begin
        tok.total_coeff   = {1'b0, flc_code[5:2]} + 5'd1;
        tok.trailing_ones = flc_code[1:0];
        tok.valid         = ({3'b000, flc_code[1:0]} <= tok.total_coeff);
      end
    end else begin
      // Lz picks the segment; an all-zero code body sits in every segment at or past its length.
      for (int i = 0; i < N_ENT; i++) begin
        e_len  = ent_len(cls, i);
        e_bits = ent_bits(cls, i);
        mask   = ~(16'hFFFF >> e_len);
        pat    = {12'b0, e_bits} << (5'd16 - e_len);
        seg_ok = (e_bits == 4'd0) ? (int'(lz) >= int'(e_len))
                                  : (int'(lz) == int'(e_len) - bitlen4(e_bits));
        if (e_len != 5'd0 && seg_ok && ((top & mask) == pat)) begin
          tok.total_coeff   = 5'(i / 4);
          tok.trailing_ones = 2'(i % 4);
          tok.num_shift     = e_len;
          tok.valid         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/coeff_token_ctrl.sv
// Sequences one coeff_token decode per Start: class select, window capture, CLZ, lookup,
// then a held shift request to the bitstream buffer until it is accepted.
module coeff_token_ctrl
  import cavlc_pkg::*;
#(
  parameter int WIN_W   = 16,
  parameter int SHIFT_W = 5
) (
  input logic               clk,
  input logic               rst,
  coeff_token_ctrl_if.slave bus
);
  localparam int LZ_W = $clog2(WIN_W + 1);

  state_t           state;
  nc_class_t        cls;
  logic [WIN_W-1:0] win_reg;
  logic [LZ_W-1:0]  lz_reg;
  coeff_token_t     tok;
  coeff_token_t     tok_reg;

  function automatic logic [LZ_W-1:0] clz(input logic [WIN_W-1:0] w);
    logic [LZ_W-1:0] n;
    n = LZ_W'(WIN_W);
    for (int i = 0; i < WIN_W; i++) begin
      if (w[i]) n = LZ_W'(WIN_W - 1 - i);
    end
    return n;
  endfunction

  coeff_token_table #(.WIN_W(WIN_W), .LZ_W(LZ_W)) u_table (
    .cls    (cls),
    .lz     (lz_reg),
    .window (win_reg),
    .tok    (tok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cls               <= CHROMA_DC;
      win_reg           <= '0;
      lz_reg            <= '0;
      tok_reg           <= '0;
      bus.shift_valid   <= 1'b0;
      bus.shift_amt     <= '0;
      bus.total_coeff   <= '0;
      bus.trailing_ones <= '0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (nc_legal(bus.nc)) begin
              cls   <= nc_to_class(bus.nc);
              state <= FETCH;
            end else begin
              bus.error <= 1'b1;
              state     <= ERROR;
            end
          end
        end
        FETCH: begin
          if (bus.window_valid) begin
            win_reg <= bus.bit_window;
            state   <= CLZ;
          end
        end
        CLZ: begin
          lz_reg <= clz(win_reg);
          state  <= LOOKUP;
        end
        LOOKUP: begin
          // Branch on the live lookup so the shift request appears the cycle after LOOKUP.
          tok_reg <= tok;
          if (tok.valid) begin
            bus.shift_valid <= 1'b1;
            bus.shift_amt   <= SHIFT_W'(tok.num_shift);
            state           <= SHIFT;
          end else begin
            bus.error <= 1'b1;
            state     <= ERROR;
          end
        end
        SHIFT: begin
          if (bus.shift_ready) begin
            bus.shift_valid   <= 1'b0;
            bus.shift_amt     <= '0;
            bus.total_coeff   <= tok_reg.total_coeff;
            bus.trailing_ones <= tok_reg.trailing_ones;
            bus.done          <= 1'b1;
            state             <= DONE;
          end else begin
            bus.shift_valid <= tok_reg.valid;
            bus.shift_amt   <= SHIFT_W'(tok_reg.num_shift);
          end
        end
        DONE, ERROR: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Directed vector bench for coeff_token_ctrl: table-driven decodes plus backpressure and reset sequences.
module tb_coeff_token_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coeff_token_ctrl_if #(.WIN_W(16), .SHIFT_W(5)) bus ();

  coeff_token_ctrl #(.WIN_W(16), .SHIFT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [5:0] nc;
    logic [15:0]       win;
    int                err_cyc;   // 0: decode succeeds; otherwise cycle of the Error pulse
    int                amt;
    int                tc;
    int                t1;
  } vec_t;

  vec_t vecs [17];
  int   n_chk = 0;
  int   n_fail = 0;
  int   hold_tc = 0;
  int   hold_t1 = 0;
  int   sv_cyc, amt_seen, done_cyc, err_cyc, tc_seen, t1_seen, tc_at_err, t1_at_err;
  int   busy_hist [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start in cycle 0, then observe cycles 1..11 mid-cycle.
  task automatic run_decode(input logic signed [5:0] nc, input logic [15:0] win);
    sv_cyc = -1; amt_seen = -1; done_cyc = -1; err_cyc = -1;
    tc_seen = -1; t1_seen = -1; tc_at_err = -1; t1_at_err = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.nc = nc; bus.bit_window = win;
    busy_hist[0] = int'(bus.busy);
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      busy_hist[c] = int'(bus.busy);
      if (bus.shift_valid && sv_cyc < 0) begin sv_cyc = c; amt_seen = int'(bus.shift_amt); end
      if (bus.done && done_cyc < 0) begin
        done_cyc = c; tc_seen = int'(bus.total_coeff); t1_seen = int'(bus.trailing_ones);
      end
      if (bus.error && err_cyc < 0) begin
        err_cyc = c; tc_at_err = int'(bus.total_coeff); t1_at_err = int'(bus.trailing_ones);
      end
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    run_decode(v.nc, v.win);
    if (v.err_cyc == 0) begin
      chk({tag, "_shift_cycle"}, sv_cyc, 4);
      chk({tag, "_shift_amt"}, amt_seen, v.amt);
      chk({tag, "_done_cycle"}, done_cyc, 5);
      chk({tag, "_tc"}, tc_seen, v.tc);
      chk({tag, "_t1"}, t1_seen, v.t1);
      chk({tag, "_no_error"}, err_cyc, -1);
      chk({tag, "_busy_c5"}, busy_hist[5], 1);
      chk({tag, "_busy_c6"}, busy_hist[6], 0);
      hold_tc = v.tc;
      hold_t1 = v.t1;
    end else begin
      chk({tag, "_error_cycle"}, err_cyc, v.err_cyc);
      chk({tag, "_no_shift"}, sv_cyc, -1);
      chk({tag, "_no_done"}, done_cyc, -1);
      chk({tag, "_tc_held"}, tc_at_err, hold_tc);
      chk({tag, "_t1_held"}, t1_at_err, hold_t1);
      chk({tag, "_busy_after"}, busy_hist[v.err_cyc + 1], 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int dcount;
    bus.start = 1'b0; bus.nc = '0; bus.bit_window = '0;
    bus.window_valid = 1'b1; bus.shift_ready = 1'b1;

    vecs[0]  = '{6'sd0,  16'h8000, 0, 1,  0,  0};  // C0 "1"
    vecs[1]  = '{6'sd1,  16'h003C, 0, 14, 9,  0};
    vecs[2]  = '{6'sd1,  16'h0020, 0, 14, 12, 3};
    vecs[3]  = '{6'sd8,  16'h0C00, 0, 6,  0,  0};  // FLC 000011
    vecs[4]  = '{6'sd8,  16'h5800, 0, 6,  6,  2};  // FLC 010110
    vecs[5]  = '{6'sd8,  16'h0800, 4, 0,  0,  0};  // FLC 000010: T1=2 > TC=1
    vecs[6]  = '{-6'sd1, 16'h8000, 0, 1,  1,  1};  // chroma DC "1"
    vecs[7]  = '{6'sd0,  16'h0000, 4, 0,  0,  0};  // no C0 code
    vecs[8]  = '{6'sd17, 16'h8000, 1, 0,  0,  0};  // illegal nC
    vecs[9]  = '{-6'sd2, 16'h8000, 1, 0,  0,  0};  // illegal nC
    vecs[10] = '{6'sd2,  16'hC000, 0, 2,  0,  0};  // C1 "11"
    vecs[11] = '{6'sd5,  16'h0040, 0, 10, 16, 0};  // C2 0000000001
    vecs[12] = '{6'sd16, 16'hFC00, 0, 6,  16, 3};  // FLC 111111
    vecs[13] = '{-6'sd1, 16'h0100, 0, 7,  4,  3};  // chroma DC 0000000
    vecs[14] = '{6'sd3,  16'h5000, 0, 4,  3,  3};  // C1 0101
    vecs[15] = '{6'sd7,  16'hF000, 0, 4,  0,  0};  // C2 1111
    vecs[16] = '{6'sd0,  16'h4000, 0, 2,  1,  1};  // C0 01

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_shift_valid", int'(bus.shift_valid), 0);
    chk("rst_shift_amt", int'(bus.shift_amt), 0);
    chk("rst_tc", int'(bus.total_coeff), 0);
    chk("rst_t1", int'(bus.trailing_ones), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) do_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: ShiftReady low for cycles 4..6, Start pulse while busy must be dropped.
    bus.shift_ready = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.nc = 6'sd0; bus.bit_window = 16'h8000;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 4; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_shift_valid", c), int'(bus.shift_valid), 1);
      chk($sformatf("bp_c%0d_shift_amt", c), int'(bus.shift_amt), 1);
      chk($sformatf("bp_c%0d_done", c), int'(bus.done), 0);
      bus.start = (c == 5);
    end
    @(negedge clk);  // cycle 7: accepted at the following edge
    chk("bp_c7_shift_valid", int'(bus.shift_valid), 1);
    chk("bp_c7_shift_amt", int'(bus.shift_amt), 1);
    bus.shift_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", int'(bus.done), 1);
    chk("bp_shift_dropped", int'(bus.shift_valid), 0);
    chk("bp_tc", int'(bus.total_coeff), 0);
    chk("bp_t1", int'(bus.trailing_ones), 0);
    @(negedge clk);
    chk("bp_done_one_cycle", int'(bus.done), 0);
    chk("bp_idle", int'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_start_not_queued", int'(bus.busy), 0);

    // Reset during SHIFT with a nonzero previous result.
    do_vec(vecs[2], "pre_rst");
    bus.shift_ready = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.nc = 6'sd1; bus.bit_window = 16'h003C;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mr_shift_valid_before", int'(bus.shift_valid), 1);
    chk("mr_shift_amt_before", int'(bus.shift_amt), 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.shift_ready = 1'b1;
    chk("mr_shift_valid", int'(bus.shift_valid), 0);
    chk("mr_shift_amt", int'(bus.shift_amt), 0);
    chk("mr_tc", int'(bus.total_coeff), 0);
    chk("mr_t1", int'(bus.trailing_ones), 0);
    chk("mr_done", int'(bus.done), 0);
    chk("mr_error", int'(bus.error), 0);
    chk("mr_busy", int'(bus.busy), 0);
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done || bus.shift_valid) dcount++;
    end
    chk("mr_no_late_activity", dcount, 0);
    hold_tc = 0;
    hold_t1 = 0;
    do_vec(vecs[16], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
